// File: rtl/gen_fip_max_selector.sv
`default_nettype none
// ============================================================================
// Module   : gen_fip_max_selector
// Brief    : Streams NUM_CNT signed fixed-point values, asks an external
//            ">=" comparator (start/done handshake) to compare each candidate
//            against the running best, and reports the maximum and the
//            arrival index where it first appeared.
// Revision : 1.0 - initial release
// ============================================================================
module gen_fip_max_selector #(
    parameter  int NUM_INT_W   = 4,
    parameter  int NUM_FRACT_W = 4,
    parameter  int NUM_CNT     = 8,
    localparam int NUM_W       = NUM_INT_W + NUM_FRACT_W,
    localparam int IDX_W       = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start_pls,
    input  logic             i_num_vld,
    input  logic [NUM_W-1:0] i_num,
    output logic             o_num_rdy,
    output logic             o_cmp_start_pls,
    output logic [NUM_W-1:0] o_cmp_num1,
    output logic [NUM_W-1:0] o_cmp_num2,
    input  logic             i_cmp_done_pls,
    input  logic             i_cmp_res,
    output logic             o_done_pls,
    output logic [NUM_W-1:0] o_max,
    output logic [IDX_W-1:0] o_max_idx,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_NUM = 3'd1,
        S_CMP_REQ  = 3'd2,
        S_CMP_WAIT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Counter is one bit wider than the index so it can reach NUM_CNT itself.
    localparam logic [IDX_W:0] c_CNT_END = (IDX_W + 1)'(NUM_CNT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W:0]     r_cnt;
    logic [NUM_W-1:0]   r_best;
    logic [IDX_W-1:0]   r_best_idx;
    logic [NUM_W-1:0]   r_cand;
    logic [NUM_W-1:0]   r_max;
    logic [IDX_W-1:0]   r_max_idx;

    logic               w_xfer;
    logic               w_resolve;
    logic               w_first;
    logic               w_last;
    logic [IDX_W:0]     w_cnt_inc;
    logic [NUM_W-1:0]   w_new_best;
    logic [IDX_W-1:0]   w_new_idx;

    assign w_xfer     = (r_state == S_WAIT_NUM) && i_num_vld;
    assign w_resolve  = ((r_state == S_CMP_REQ) || (r_state == S_CMP_WAIT)) && i_cmp_done_pls;
    assign w_first    = (r_cnt == '0);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_last     = (w_cnt_inc == c_CNT_END);
    // i_cmp_res==1 means best>=candidate, so ties keep the earlier value.
    assign w_new_best = i_cmp_res ? r_best     : r_cand;
    assign w_new_idx  = i_cmp_res ? r_best_idx : r_cnt[IDX_W-1:0];

    assign o_num_rdy       = (r_state == S_WAIT_NUM);
    assign o_cmp_start_pls = (r_state == S_CMP_REQ);
    assign o_done_pls      = (r_state == S_DONE);
    assign o_busy          = (r_state == S_WAIT_NUM) || (r_state == S_CMP_REQ)
                          || (r_state == S_CMP_WAIT);
    assign o_cmp_num1      = r_best;
    assign o_cmp_num2      = r_cand;
    assign o_max           = r_max;
    assign o_max_idx       = r_max_idx;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection; a same-cycle done in CMP_REQ skips CMP_WAIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start_pls) w_state_nxt = S_WAIT_NUM;
            end
            S_WAIT_NUM: begin
                if (i_num_vld) begin
                    if (!w_first)   w_state_nxt = S_CMP_REQ;
                    else if (w_last) w_state_nxt = S_DONE;
                end
            end
            S_CMP_REQ: begin
                if (i_cmp_done_pls) w_state_nxt = w_last ? S_DONE : S_WAIT_NUM;
                else                w_state_nxt = S_CMP_WAIT;
            end
            S_CMP_WAIT: begin
                if (i_cmp_done_pls) w_state_nxt = w_last ? S_DONE : S_WAIT_NUM;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: load first value, latch candidates, fold comparator verdicts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_cand     <= '0;
            r_max      <= '0;
            r_max_idx  <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start_pls) begin
                r_cnt <= '0;
            end
            if (w_xfer) begin
                if (w_first) begin
                    r_best     <= i_num;
                    r_best_idx <= '0;
                    r_cnt      <= w_cnt_inc;
                    if (w_last) begin
                        r_max     <= i_num;
                        r_max_idx <= '0;
                    end
                end else begin
                    r_cand <= i_num;
                end
            end
            if (w_resolve) begin
                r_best     <= w_new_best;
                r_best_idx <= w_new_idx;
                r_cnt      <= w_cnt_inc;
                if (w_last) begin
                    r_max     <= w_new_best;
                    r_max_idx <= w_new_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gen_fip_max_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_fip_max_selector
// Brief    : Self-checking bench for gen_fip_max_selector with NUM_CNT=8,4,1
//            instances, a configurable-latency comparator and a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_fip_max_selector;

    localparam int c_CNT [3] = '{8, 4, 1};

    logic       clk;
    logic       rstn;
    logic [2:0] start, vld, rdy, cstart, cdone, cres, done, busy, stray;
    logic [7:0] num [3];
    logic [7:0] n1  [3];
    logic [7:0] n2  [3];
    logic [7:0] mx  [3];
    logic [2:0] idx [3];
    int         lat;
    int         total;
    int         bad;
    logic [7:0] vecs [6][8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // First-occurrence signed maximum of q[0..n-1].
    function automatic void best_of(input logic [7:0] q[$], input int n,
                                    output logic [7:0] v, output logic [31:0] ix);
        v  = q[0];
        ix = 0;
        for (int i = 1; i < n; i++) begin
            if ($signed(q[i]) > $signed(v)) begin
                v  = q[i];
                ix = i;
            end
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int N  = c_CNT[g];
        localparam int IW = (N > 1) ? $clog2(N) : 1;
        logic [IW-1:0] w_idx;
        logic [3:0]    r_wait;

        assign idx[g] = 3'(w_idx);

        gen_fip_max_selector #(.NUM_INT_W(4), .NUM_FRACT_W(4), .NUM_CNT(N)) u_dut (
            .clk             (clk),
            .rstn            (rstn),
            .i_start_pls     (start[g]),
            .i_num_vld       (vld[g]),
            .i_num           (num[g]),
            .o_num_rdy       (rdy[g]),
            .o_cmp_start_pls (cstart[g]),
            .o_cmp_num1      (n1[g]),
            .o_cmp_num2      (n2[g]),
            .i_cmp_done_pls  (cdone[g]),
            .i_cmp_res       (cres[g]),
            .o_done_pls      (done[g]),
            .o_max           (mx[g]),
            .o_max_idx       (w_idx),
            .o_busy          (busy[g])
        );

        // Comparator: same-cycle answer when lat==0, otherwise lat cycles later.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)                    r_wait <= '0;
            else if (cstart[g] && lat != 0) r_wait <= 4'(lat);
            else if (r_wait != 0)         r_wait <= r_wait - 1'b1;
        end
        assign cdone[g] = ((lat == 0) ? cstart[g] : (r_wait == 4'd1)) | stray[g];
        assign cres[g]  = $signed(n1[g]) >= $signed(n2[g]);

        // Reference model and per-cycle compare.
        initial begin : chk_proc
            logic [7:0]  q[$];
            logic [7:0]  hmax, bv;
            logic [31:0] hidx, bi;
            bit active, in_cmp, req_first, exp_done, was_done;
            int starts;
            hmax = 0; hidx = 0; active = 0; in_cmp = 0; req_first = 0;
            exp_done = 0; starts = 0;
            forever begin
                @(negedge clk);
                if (!rstn) begin
                    chk($sformatf("d%0d_rst_busy", g), busy[g], 0);
                    chk($sformatf("d%0d_rst_rdy", g), rdy[g], 0);
                    chk($sformatf("d%0d_rst_cstart", g), cstart[g], 0);
                    chk($sformatf("d%0d_rst_done", g), done[g], 0);
                    chk($sformatf("d%0d_rst_n1", g), n1[g], 0);
                    chk($sformatf("d%0d_rst_n2", g), n2[g], 0);
                    chk($sformatf("d%0d_rst_max", g), mx[g], 0);
                    chk($sformatf("d%0d_rst_idx", g), idx[g], 0);
                    q.delete();
                    hmax = 0; hidx = 0; active = 0; in_cmp = 0; req_first = 0;
                    exp_done = 0; starts = 0;
                    continue;
                end
                if (exp_done) best_of(q, q.size(), hmax, hidx);
                chk($sformatf("d%0d_done", g), done[g], exp_done);
                chk($sformatf("d%0d_busy", g), busy[g], active);
                chk($sformatf("d%0d_rdy", g), rdy[g], active && !in_cmp);
                chk($sformatf("d%0d_cstart", g), cstart[g], in_cmp && req_first);
                chk($sformatf("d%0d_max", g), mx[g], hmax);
                chk($sformatf("d%0d_idx", g), idx[g], hidx);
                if (in_cmp) begin
                    best_of(q, q.size() - 1, bv, bi);
                    chk($sformatf("d%0d_num1", g), n1[g], bv);
                    chk($sformatf("d%0d_num2", g), n2[g], q[q.size()-1]);
                end
                was_done = exp_done;
                exp_done = 0;
                if (was_done) begin
                    chk($sformatf("d%0d_nstarts", g), starts, N - 1);
                    q.delete();
                    starts = 0;
                end
                if (cstart[g]) starts++;
                if (in_cmp) begin
                    req_first = 0;
                    if (cdone[g]) begin
                        in_cmp = 0;
                        if (q.size() == N) begin
                            active   = 0;
                            exp_done = 1;
                        end
                    end
                end else if (active) begin
                    if (vld[g]) begin
                        q.push_back(num[g]);
                        if (q.size() >= 2) begin
                            in_cmp    = 1;
                            req_first = 1;
                        end else if (N == 1) begin
                            active   = 0;
                            exp_done = 1;
                        end
                    end
                end else if (!was_done && start[g]) begin
                    active = 1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input logic [7:0] v);
        bit ok;
        ok     = 0;
        vld[g] = 1'b1;
        num[g] = v;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ok = rdy[g];
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk($sformatf("d%0d_send_timeout", g), 0, 1);
        vld[g] = 1'b0;
    endtask

    task automatic begin_search(input int g);
        tick;
        start[g] = 1'b1;
        tick;
        start[g] = 1'b0;
    endtask

    task automatic feed(input int g, input int vi, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick;
            send(g, vecs[vi][i]);
        end
    endtask

    // Returns at the negedge where o_done_pls is seen.
    task automatic wait_done(input int g);
        bit seen;
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done[g]) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk($sformatf("d%0d_done_timeout", g), 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; lat = 0;
        rstn = 1'b0; start = '0; vld = '0; stray = '0;
        for (int i = 0; i < 3; i++) num[i] = '0;
        vecs[0] = '{8'h10, 8'hF0, 8'h28, 8'h18, 8'h40, 8'h08, 8'h00, 8'h3F};
        vecs[1] = '{8'hF8, 8'hE0, 8'hFC, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'h30, 8'h30, 8'h10, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{8'h20, 8'h50, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{8'h08, 8'h7F, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Eight values, zero-latency comparator.
        begin_search(0);
        feed(0, 0, 8, 0);
        wait_done(0);
        chk("s1_max", mx[0], 8'h40);
        chk("s1_idx", idx[0], 4);
        tick;

        // All negative.
        begin_search(1);
        feed(1, 1, 4, 0);
        wait_done(1);
        chk("neg_max", mx[1], 8'hFC);
        chk("neg_idx", idx[1], 2);
        tick;

        // Ties keep first occurrence.
        begin_search(1);
        feed(1, 2, 4, 0);
        wait_done(1);
        chk("tie_max", mx[1], 8'h30);
        chk("tie_idx", idx[1], 0);
        tick;

        // Single value search.
        begin_search(2);
        feed(2, 3, 1, 0);
        wait_done(2);
        chk("one_max", mx[2], 8'h85);
        chk("one_idx", idx[2], 0);
        tick;

        // Three-cycle comparator with random source gaps.
        lat = 3;
        begin_search(0);
        feed(0, 0, 8, 1);
        wait_done(0);
        chk("lat_max", mx[0], 8'h40);
        chk("lat_idx", idx[0], 4);
        tick;

        // Stray start while busy and stray done in WAIT_NUM.
        lat = 0;
        begin_search(0);
        feed(0, 0, 3, 0);
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        stray[0] = 1'b1;
        tick;
        stray[0] = 1'b0;
        for (int i = 3; i < 8; i++) send(0, vecs[0][i]);
        wait_done(0);
        chk("stray_max", mx[0], 8'h40);
        chk("stray_idx", idx[0], 4);
        tick;

        // Asynchronous reset during CMP_WAIT of the third value.
        lat = 3;
        begin_search(1);
        feed(1, 4, 3, 0);
        tick;
        rstn = 1'b0;
        #1;
        chk("arst_busy", busy[1], 0);
        chk("arst_n1", n1[1], 0);
        chk("arst_n2", n2[1], 0);
        chk("arst_max", mx[1], 0);
        chk("arst_max0", mx[0], 0);
        repeat (2) tick;
        rstn = 1'b1;
        stray[1] = 1'b1;
        tick;
        stray[1] = 1'b0;
        chk("post_rst_busy", busy[1], 0);
        begin_search(1);
        feed(1, 5, 4, 1);
        wait_done(1);
        chk("rst_max", mx[1], 8'h7F);
        chk("rst_idx", idx[1], 1);
        repeat (3) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
